// File: rtl/fp_adder_arbiter.sv
// Round-robin sequencer sharing one combinational 16-bit add/sub among NREQ requesters.
// Accept at t, adder sampled at t+1, rsp_valid from t+2; one op in flight, req_ready held low until the response is taken.
module fp_adder_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*16-1:0]   req_a,
   input  logic [NREQ*16-1:0]   req_b,
   input  logic [NREQ-1:0]      req_op,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [15:0]          rsp_data,
   output logic [15:0]          add_a,
   output logic [15:0]          add_b,
   output logic                 add_op,
   input  logic [15:0]          add_result,
   output logic                 busy,
   output logic [IDW-1:0]       gnt_id
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        op;
   } opnd_t;

   state_t          state;
   opnd_t           opnd_q;
   opnd_t           sel_opnd;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  ptr_nxt;
   logic [IDW-1:0]  win;
   logic [IDW-1:0]  idx;
   logic            found;
   logic [NREQ-1:0] rsp_valid_q;

   // First valid requester at or after ptr, wrapping at NREQ-1.
   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IDW'((int'(ptr) + k) % NREQ);
         if (!found && req_valid[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      sel_opnd = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (win == IDW'(k)) begin
            sel_opnd.a  = req_a[k*16 +: 16];
            sel_opnd.b  = req_b[k*16 +: 16];
            sel_opnd.op = req_op[k];
         end
      end
   end

   assign ptr_nxt   = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
   // Gated by rst so no grant is offered while reset is held.
   assign req_ready = (rst && state == IDLE && found) ? (NREQ'(1) << win) : '0;
   assign rsp_valid = rsp_valid_q;
   assign add_a     = opnd_q.a;
   assign add_b     = opnd_q.b;
   assign add_op    = opnd_q.op;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         opnd_q      <= '0;
         ptr         <= '0;
         gnt_id      <= '0;
         rsp_data    <= '0;
         rsp_valid_q <= '0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  opnd_q <= sel_opnd;
                  gnt_id <= win;
                  ptr    <= ptr_nxt;
                  busy   <= 1'b1;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               rsp_data    <= add_result;
               rsp_valid_q <= NREQ'(1) << gnt_id;
               state       <= RESP;
            end
            RESP: begin
               if (rsp_ready[gnt_id]) begin
                  rsp_valid_q <= '0;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Bench for fp_adder_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_fp_adder_arbiter;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                 clk, rst;
   logic [NREQ-1:0]      req_valid, req_ready, req_op, rsp_valid, rsp_ready;
   logic [NREQ*16-1:0]   req_a, req_b;
   logic [15:0]          rsp_data, add_a, add_b, add_result;
   logic                 add_op, busy;
   logic [IDW-1:0]       gnt_id;

   int checks = 0;
   int errors = 0;

   // Shared adder stand-in.
   assign add_result = add_op ? add_a - add_b : add_a + add_b;

   fp_adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .add_a(add_a), .add_b(add_b), .add_op(add_op), .add_result(add_result),
      .busy(busy), .gnt_id(gnt_id)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Transaction model: an op is in flight for issue + response cycles.
   bit          m_busy;
   int          m_age, m_id, m_ptr;
   logic [15:0] m_a, m_b, m_res;
   logic        m_op;
   int          glog[$];
   int          rid[$];
   logic [15:0] rres[$];

   always @(negedge clk) begin
      logic [NREQ-1:0] e_rr, e_rv;
      int w;
      if (!rst) begin
         m_busy = 0; m_age = 0; m_id = 0; m_ptr = 0;
         m_a = 0; m_b = 0; m_op = 0; m_res = 0;
         chk("rst_req_ready", req_ready, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_gnt_id", gnt_id, 0);
         chk("rst_add_a", add_a, 0);
         chk("rst_add_b", add_b, 0);
         chk("rst_add_op", add_op, 0);
      end else begin
         e_rr = '0; e_rv = '0; w = -1;
         if (!m_busy) begin
            for (int k = 0; k < NREQ; k++) begin
               int j;
               j = (m_ptr + k) % NREQ;
               if (w < 0 && req_valid[j]) w = j;
            end
         end
         if (w >= 0) e_rr[w] = 1'b1;
         if (m_busy && m_age >= 2) e_rv[m_id] = 1'b1;
         chk("req_ready", req_ready, e_rr);
         chk("rsp_valid", rsp_valid, e_rv);
         chk("busy", busy, m_busy);
         chk("gnt_id", gnt_id, m_id);
         chk("add_a", add_a, m_a);
         chk("add_b", add_b, m_b);
         chk("add_op", add_op, m_op);
         if (e_rv != 0) chk("rsp_data", rsp_data, m_res);
         if (w >= 0) begin
            m_busy = 1; m_age = 1; m_id = w;
            m_a = req_a[w*16 +: 16];
            m_b = req_b[w*16 +: 16];
            m_op = req_op[w];
            m_res = m_op ? m_a - m_b : m_a + m_b;
            m_ptr = (w + 1) % NREQ;
            glog.push_back(w);
         end else if (m_busy && m_age == 1) begin
            m_age = 2;
         end else if (m_busy && rsp_ready[m_id]) begin
            rid.push_back(m_id);
            rres.push_back(m_res);
            m_busy = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic op);
      req_a[i*16 +: 16] = a;
      req_b[i*16 +: 16] = b;
      req_op[i]         = op;
   endtask

   int          bc;
   int          exp_g[5]  = '{0, 1, 2, 3, 0};
   logic [15:0] exp_r[4]  = '{16'h1011, 16'h1FDE, 16'h3033, 16'h3FBC};
   int          exp_f[4]  = '{1, 3, 1, 3};

   initial begin
      req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = '1;
      rst = 1'b1;
      #2 rst = 1'b0;
      tick(); tick();
      chk("reset_busy", busy, 0);
      chk("reset_gnt_id", gnt_id, 0);
      req_valid = '1;
      #1;
      chk("reset_req_ready_gated", req_ready, 0);
      req_valid = '0;
      tick();
      rst = 1'b1;

      // Single request from requester 2
      set_req(2, 16'h0003, 16'h0005, 1'b0);
      req_valid = 4'b0100;
      #1;
      chk("t1_req_ready", req_ready, 4'b0100);
      bc = int'(busy);
      tick(); req_valid = '0; #1;
      bc += int'(busy);
      chk("t1_add_a", add_a, 16'h0003);
      tick();
      chk("t1_rsp_valid", rsp_valid, 4'b0100);
      chk("t1_rsp_data", rsp_data, 16'h0008);
      bc += int'(busy);
      tick();
      bc += int'(busy);
      chk("t1_busy_cycles", bc, 2);

      // Subtract with wrap from requester 0
      set_req(0, 16'h0001, 16'h0002, 1'b1);
      req_valid = 4'b0001;
      #1;
      chk("t2_req_ready", req_ready, 4'b0001);
      tick(); req_valid = '0;
      tick();
      chk("t2_rsp_valid", rsp_valid, 4'b0001);
      chk("t2_rsp_data", rsp_data, 16'hFFFF);
      tick();

      // Requester 3 alone brings the pointer back to 0
      set_req(3, 16'h1234, 16'h1111, 1'b0);
      req_valid = 4'b1000;
      tick(); req_valid = '0;
      tick();
      chk("t3_pre_rsp_data", rsp_data, 16'h2345);
      tick();
      chk("t3_gnt_hold", gnt_id, 3);

      // All four continuously valid
      for (int i = 0; i < NREQ; i++)
         set_req(i, 16'(16'h1000 * (i + 1)), 16'(16'h0011 * (i + 1)), 1'(i % 2));
      glog.delete(); rid.delete(); rres.delete();
      req_valid = '1;
      repeat (13) tick();
      req_valid = '0;
      repeat (3) tick();
      chk("t3_grant_count", glog.size(), 5);
      for (int k = 0; k < 5; k++)
         if (k < glog.size()) chk($sformatf("t3_grant%0d", k), glog[k], exp_g[k]);
      chk("t3_rsp_count", rid.size(), 5);
      for (int k = 0; k < 5; k++)
         if (k < rid.size()) begin
            chk($sformatf("t3_rsp_id%0d", k), rid[k], exp_g[k]);
            chk($sformatf("t3_rsp_data%0d", k), rres[k], exp_r[exp_g[k]]);
         end

      // Response backpressure on requester 1; other rsp_ready bits ignored
      rsp_ready = 4'b1101;
      set_req(1, 16'h00FF, 16'h0001, 1'b0);
      req_valid = 4'b0110;
      #1;
      chk("t4_req_ready", req_ready, 4'b0010);
      tick(); req_valid = 4'b0100;
      tick();
      for (int s = 0; s < 5; s++) begin
         chk("t4_stall_rsp_valid", rsp_valid, 4'b0010);
         chk("t4_stall_rsp_data", rsp_data, 16'h0100);
         chk("t4_stall_req_ready", req_ready, 4'b0000);
         tick();
      end
      rsp_ready = '1;
      #1;
      chk("t4_release_rsp_valid", rsp_valid, 4'b0010);
      tick();
      chk("t4_done_rsp_valid", rsp_valid, 4'b0000);
      chk("t4_next_grant", req_ready, 4'b0100);
      tick(); req_valid = '0;
      tick(); tick(); tick();

      // Reset asserted during ISSUE
      set_req(0, 16'h0005, 16'h0006, 1'b0);
      req_valid = 4'b0001;
      #1;
      chk("t5_req_ready", req_ready, 4'b0001);
      tick(); req_valid = '0;
      chk("t5_busy_issue", busy, 1);
      rst = 1'b0;
      #1;
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_rsp_valid", rsp_valid, 0);
      chk("t5_rst_gnt_id", gnt_id, 0);
      chk("t5_rst_add_a", add_a, 0);
      tick();
      rst = 1'b1;
      for (int s = 0; s < 3; s++) begin
         chk("t5_no_rsp", rsp_valid, 0);
         tick();
      end

      // Fairness between requesters 1 and 3
      glog.delete();
      req_valid = 4'b1010;
      #1;
      chk("t6_first_grant", req_ready, 4'b0010);
      repeat (10) tick();
      req_valid = '0;
      repeat (3) tick();
      chk("t6_grant_count", glog.size(), 4);
      for (int k = 0; k < 4; k++)
         if (k < glog.size()) chk($sformatf("t6_grant%0d", k), glog[k], exp_f[k]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
